sincronizador_vga: RTL and testbench
====================================

Name: sincronizador_vga

Overview:
VGA 640x480@60 Hz timing generator. It sits directly upstream of the tile/font renderer and drives the renderer's Qh/Qv pixel coordinates. It divides the system clock down to a pixel-rate enable, runs the horizontal and vertical counters, and decodes hsync, vsync and video_on. It also provides copies of the sync and blanking signals delayed by a fixed number of clocks, so they line up with the renderer's registered font-bit output.

Parameters:
DIV, 4, system clocks per pixel (100 MHz -> 25 MHz); legal range 1..16
H_VISIBLE, 640, visible pixels per line
H_FP, 16, horizontal front porch in pixels
H_SYNC, 96, horizontal sync width in pixels
H_BP, 48, horizontal back porch in pixels
V_VISIBLE, 480, visible lines per frame
V_FP, 10, vertical front porch in lines
V_SYNC, 2, vertical sync width in lines
V_BP, 33, vertical back porch in lines
SYNC_ACTIVE, 0, asserted level of hsync/vsync (0 = active-low)
DELAY, 2, pipeline depth in clocks for the *_d outputs; legal range 0..7

Ports:
reloj  input  1  system clock; all state on rising edge
resetM  input  1  asynchronous, active-high reset
Qh  output  10  horizontal pixel counter, 0..H_TOTAL-1
Qv  output  10  vertical line counter, 0..V_TOTAL-1
pixel_tick  output  1  one-clock pulse; pixel-rate enable
hsync  output  1  horizontal sync, aligned with Qh/Qv
vsync  output  1  vertical sync, aligned with Qh/Qv
video_on  output  1  high when (Qh,Qv) is inside the visible area
fin_cuadro  output  1  one-clock pulse on the last pixel of a frame
hsync_d  output  1  hsync delayed DELAY clocks
vsync_d  output  1  vsync delayed DELAY clocks
video_on_d  output  1  video_on delayed DELAY clocks

Behaviour:
- Derived constants:
  - H_TOTAL = sum of the H_* parameters = 800.
  - V_TOTAL = sum of the V_* parameters = 525.
- Divider:
  - Counter div_cnt runs 0..DIV-1 and wraps to 0.
  - pixel_tick = 1 in the clock where div_cnt == DIV-1.
  - DIV=1: pixel_tick is held 1 from the first clock after reset release.
- Horizontal counter:
  - Qh advances only on cycles where pixel_tick = 1.
  - Qh == H_TOTAL-1 wraps to 0; otherwise Qh increments by 1.
- Vertical counter:
  - Qv advances only on a pixel_tick cycle where Qh == H_TOTAL-1.
  - Qv == V_TOTAL-1 wraps to 0; otherwise Qv increments by 1.
- Decode:
  - hsync, vsync and video_on are registers loaded from the next-state counter values, so they change on the same edge as Qh/Qv. There is no combinational glitching.
  - hsync = SYNC_ACTIVE when H_VISIBLE+H_FP <= Qh < H_VISIBLE+H_FP+H_SYNC (656..751); otherwise ~SYNC_ACTIVE.
  - vsync = SYNC_ACTIVE when V_VISIBLE+V_FP <= Qv < V_VISIBLE+V_FP+V_SYNC (490..491); otherwise ~SYNC_ACTIVE.
  - video_on = (Qh < H_VISIBLE) && (Qv < V_VISIBLE).
- fin_cuadro:
  - Asserted combinationally as pixel_tick && Qh == H_TOTAL-1 && Qv == V_TOTAL-1.
  - Exactly one clock wide, once per frame (every 420000 pixel ticks).
- Delay line:
  - A DELAY-stage shift register advances on every reloj edge, not on pixel_tick. The renderer's latency is counted in clocks.
  - DELAY=0: the *_d outputs equal their undelayed counterparts.
- Reset (asynchronous; takes effect immediately, including mid-line or mid-frame):
  - div_cnt = 0, Qh = 0, Qv = 0, video_on = 0.
  - hsync = vsync = ~SYNC_ACTIVE.
  - Every delay stage is loaded with the inactive level (video 0, syncs ~SYNC_ACTIVE).
  - pixel_tick and fin_cuadro are 0 while resetM = 1.
  - First pixel_tick: DIV clocks after release.
- Widths:
  - 10-bit counters hold values up to 1023.
  - H_TOTAL and V_TOTAL greater than 1024 is a configuration error, flagged by an elaboration-time check.

Decomposition:
- Package vga_timing_pkg holds:
  - the default 640x480 constants;
  - H_TOTAL, V_TOTAL and the sync start/end boundary constants;
  - the SYNC_ACTIVE default.
- Sub-module divisor_pixel holds the div_cnt counter and produces pixel_tick; its parameter is DIV.
- The counters, decode and delay line stay in the top module.

Test Plan:
- Reset release, DIV=4 -> pixel_tick first high in the 4th clock, then every 4 clocks; Qh = 1 after the first tick; Qv = 0.
- Run one line -> Qh steps 0..799 then back to 0; Qv increments to 1 on the edge where Qh wraps; hsync low exactly for Qh = 656..751 (96 ticks).
- Run a full frame -> vsync low only for Qv = 490 and 491.
  - video_on high for 640x480 = 307200 ticks.
  - fin_cuadro single pulse at (799,524); Qh and Qv both 0 on the next tick.
- DELAY=2 -> hsync_d, vsync_d and video_on_d equal the undelayed signals shifted by exactly 2 reloj clocks at every transition.
- Assert resetM asynchronously (between clock edges) at Qh=300, Qv=200 -> Qh, Qv and video_on are 0 and hsync/vsync are 1 before the next edge; the count restarts cleanly after release.
- DIV=1, SYNC_ACTIVE=1 -> pixel_tick held 1; hsync high for 96 consecutive clocks per 800-clock line.

Source files
------------

// File: rtl/sincronizador_vga_pkg.sv
// Default 640x480@60 Hz VGA timing constants and small decode helpers
// shared by the sync generator and its pixel-rate divider.
package vga_timing_pkg;

    localparam int CNT_W = 10;

    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FP_DEF      = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BP_DEF      = 48;
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FP_DEF      = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BP_DEF      = 33;

    localparam int H_TOTAL_DEF = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL_DEF = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    localparam int H_SYNC_START_DEF = H_VISIBLE_DEF + H_FP_DEF;
    localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF;
    localparam int V_SYNC_START_DEF = V_VISIBLE_DEF + V_FP_DEF;
    localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF;

    localparam logic SYNC_ACTIVE_DEF = 1'b0;

    // Half-open window test: lo <= pos < hi.
    function automatic logic in_window(input logic [CNT_W-1:0] pos,
                                       input logic [CNT_W-1:0] lo,
                                       input logic [CNT_W-1:0] hi);
        return (pos >= lo) && (pos < hi);
    endfunction

    function automatic logic sync_level(input logic active, input logic sync_active);
        return active ? sync_active : ~sync_active;
    endfunction

endpackage

// File: rtl/sincronizador_vga_divisor_pixel.sv
// Divides the system clock down to a one-clock pixel-rate enable.
// With DIV=1 the enable is held high whenever reset is released.
module divisor_pixel #(
    parameter int DIV = 4
) (
    input  logic reloj,
    input  logic resetM,
    output logic pixel_tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] div_cnt_r;

    // Free-running modulo-DIV counter.
    always_ff @(posedge reloj or posedge resetM) begin
        if (resetM) begin
            div_cnt_r <= '0;
        end else if (div_cnt_r == LAST) begin
            div_cnt_r <= '0;
        end else begin
            div_cnt_r <= div_cnt_r + CW'(1);
        end
    end

    // Gated by reset so the enable is quiet while reset is held, even for DIV=1.
    assign pixel_tick = ~resetM & (div_cnt_r == LAST);

endmodule

// File: rtl/sincronizador_vga.sv
// VGA timing generator: pixel/line counters, registered sync and blanking
// decode, and a clock-domain delay line aligning them with the renderer.
module sincronizador_vga
    import vga_timing_pkg::*;
#(
    parameter int   DIV         = 4,
    parameter int   H_VISIBLE   = H_VISIBLE_DEF,
    parameter int   H_FP        = H_FP_DEF,
    parameter int   H_SYNC      = H_SYNC_DEF,
    parameter int   H_BP        = H_BP_DEF,
    parameter int   V_VISIBLE   = V_VISIBLE_DEF,
    parameter int   V_FP        = V_FP_DEF,
    parameter int   V_SYNC      = V_SYNC_DEF,
    parameter int   V_BP        = V_BP_DEF,
    parameter logic SYNC_ACTIVE = SYNC_ACTIVE_DEF,
    parameter int   DELAY       = 2
) (
    input  logic             reloj,
    input  logic             resetM,
    output logic [CNT_W-1:0] Qh,
    output logic [CNT_W-1:0] Qv,
    output logic             pixel_tick,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic             fin_cuadro,
    output logic             hsync_d,
    output logic             vsync_d,
    output logic             video_on_d
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] H_SS     = CNT_W'(H_VISIBLE + H_FP);
    localparam logic [CNT_W-1:0] H_SE     = CNT_W'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_SS     = CNT_W'(V_VISIBLE + V_FP);
    localparam logic [CNT_W-1:0] V_SE     = CNT_W'(V_VISIBLE + V_FP + V_SYNC);
    localparam logic             SYNC_OFF = ~SYNC_ACTIVE;

    if (H_TOTAL > 1024) begin : g_h_total_err
        $error("sincronizador_vga: H_TOTAL exceeds 10-bit counter range");
    end
    if (V_TOTAL > 1024) begin : g_v_total_err
        $error("sincronizador_vga: V_TOTAL exceeds 10-bit counter range");
    end
    if (DIV < 1 || DIV > 16) begin : g_div_err
        $error("sincronizador_vga: DIV outside 1..16");
    end
    if (DELAY < 0 || DELAY > 7) begin : g_delay_err
        $error("sincronizador_vga: DELAY outside 0..7");
    end

    logic             tick_s;
    logic [CNT_W-1:0] qh_r, qv_r;
    logic [CNT_W-1:0] qh_next_s, qv_next_s;
    logic             hsync_r, vsync_r, video_on_r;

    divisor_pixel #(.DIV(DIV)) u_divisor (
        .reloj      (reloj),
        .resetM     (resetM),
        .pixel_tick (tick_s)
    );

    // Next-state counter values, shared by the counters and the decode registers.
    always_comb begin
        qh_next_s = qh_r;
        qv_next_s = qv_r;
        if (tick_s) begin
            if (qh_r == H_LAST) begin
                qh_next_s = '0;
                if (qv_r == V_LAST) begin
                    qv_next_s = '0;
                end else begin
                    qv_next_s = qv_r + 10'd1;
                end
            end else begin
                qh_next_s = qh_r + 10'd1;
                qv_next_s = qv_r;
            end
        end else begin
            qh_next_s = qh_r;
            qv_next_s = qv_r;
        end
    end

    // Counters and decode registers update together so outputs stay aligned and glitch-free.
    always_ff @(posedge reloj or posedge resetM) begin
        if (resetM) begin
            qh_r       <= '0;
            qv_r       <= '0;
            hsync_r    <= SYNC_OFF;
            vsync_r    <= SYNC_OFF;
            video_on_r <= 1'b0;
        end else begin
            qh_r       <= qh_next_s;
            qv_r       <= qv_next_s;
            hsync_r    <= sync_level(in_window(qh_next_s, H_SS, H_SE), SYNC_ACTIVE);
            vsync_r    <= sync_level(in_window(qv_next_s, V_SS, V_SE), SYNC_ACTIVE);
            video_on_r <= (qh_next_s < H_VIS) && (qv_next_s < V_VIS);
        end
    end

    assign Qh         = qh_r;
    assign Qv         = qv_r;
    assign pixel_tick = tick_s;
    assign hsync      = hsync_r;
    assign vsync      = vsync_r;
    assign video_on   = video_on_r;
    assign fin_cuadro = tick_s && (qh_r == H_LAST) && (qv_r == V_LAST);

    // Delay line counts system clocks, matching the renderer's registered latency.
    if (DELAY == 0) begin : g_no_delay
        assign hsync_d    = hsync_r;
        assign vsync_d    = vsync_r;
        assign video_on_d = video_on_r;
    end else begin : g_delay
        logic [DELAY-1:0] hs_pipe_r, vs_pipe_r, vo_pipe_r;

        // Shift stage i takes stage i-1 every clock; stage 0 takes the live decode.
        always_ff @(posedge reloj or posedge resetM) begin
            if (resetM) begin
                hs_pipe_r <= {DELAY{SYNC_OFF}};
                vs_pipe_r <= {DELAY{SYNC_OFF}};
                vo_pipe_r <= '0;
            end else begin
                hs_pipe_r[0] <= hsync_r;
                vs_pipe_r[0] <= vsync_r;
                vo_pipe_r[0] <= video_on_r;
                for (int i = 1; i < DELAY; i++) begin
                    hs_pipe_r[i] <= hs_pipe_r[i-1];
                    vs_pipe_r[i] <= vs_pipe_r[i-1];
                    vo_pipe_r[i] <= vo_pipe_r[i-1];
                end
            end
        end

        assign hsync_d    = hs_pipe_r[DELAY-1];
        assign vsync_d    = vs_pipe_r[DELAY-1];
        assign video_on_d = vo_pipe_r[DELAY-1];
    end

endmodule

// File: tb/tb_sincronizador_vga.sv
// Directed bench: full-size DIV=4 instance for line timing and reset, plus a
// reduced-geometry DIV=1 active-high-sync instance for whole-frame behaviour.
module tb_sincronizador_vga;

    logic reloj = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;

    always #5 reloj = ~reloj;

    logic [9:0] qh_a, qv_a, qh_b, qv_b;
    logic tick_a, hs_a, vs_a, vo_a, fin_a, hsd_a, vsd_a, vod_a;
    logic tick_b, hs_b, vs_b, vo_b, fin_b, hsd_b, vsd_b, vod_b;

    sincronizador_vga #(.DIV(4), .DELAY(2)) dut_a (
        .reloj(reloj), .resetM(rst_a), .Qh(qh_a), .Qv(qv_a), .pixel_tick(tick_a),
        .hsync(hs_a), .vsync(vs_a), .video_on(vo_a), .fin_cuadro(fin_a),
        .hsync_d(hsd_a), .vsync_d(vsd_a), .video_on_d(vod_a)
    );

    // 15 x 12 frame: sync high at Qh 10..12 and Qv 7..8, visible 8 x 6.
    sincronizador_vga #(
        .DIV(1), .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(3),
        .SYNC_ACTIVE(1'b1), .DELAY(0)
    ) dut_b (
        .reloj(reloj), .resetM(rst_b), .Qh(qh_b), .Qv(qv_b), .pixel_tick(tick_b),
        .hsync(hs_b), .vsync(vs_b), .video_on(vo_b), .fin_cuadro(fin_b),
        .hsync_d(hsd_b), .vsync_d(vsd_b), .video_on_d(vod_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Delayed outputs of dut_a must equal the undelayed ones two samples earlier.
    logic [2:0] hist0_a, hist1_a;
    always @(negedge reloj) begin
        if (rst_a) begin
            hist0_a = 3'b110;
            hist1_a = 3'b110;
        end else begin
            chk("delay2_a", {29'd0, hsd_a, vsd_a, vod_a}, {29'd0, hist1_a});
            hist1_a = hist0_a;
            hist0_a = {hs_a, vs_a, vo_a};
        end
    end

    // With no delay stages the *_d outputs follow the live ones.
    always @(negedge reloj) begin
        if (!rst_b) begin
            chk("delay0_b", {29'd0, hsd_b, vsd_b, vod_b}, {29'd0, hs_b, vs_b, vo_b});
        end
    end

    typedef struct {
        int         k;
        logic [9:0] qh;
        logic [9:0] qv;
        logic       tick;
        logic       hs;
        logic       vs;
        logic       vo;
    } vec_t;

    vec_t tbl[16];
    int   k_a;

    initial begin
        int fin_seen, hs_cnt, vs_cnt, vo_cnt, tick_cnt, bad_vs, run, bad_run, runs;
        logic prev_fin, prev_hs;

        tbl[0]  = '{1,    10'd0,   10'd0, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[1]  = '{2,    10'd0,   10'd0, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[2]  = '{3,    10'd0,   10'd0, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[3]  = '{4,    10'd1,   10'd0, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[4]  = '{7,    10'd1,   10'd0, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[5]  = '{8,    10'd2,   10'd0, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[6]  = '{2559, 10'd639, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[7]  = '{2560, 10'd640, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[8]  = '{2623, 10'd655, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[9]  = '{2624, 10'd656, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{3007, 10'd751, 10'd0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{3008, 10'd752, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[12] = '{3199, 10'd799, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[13] = '{3200, 10'd0,   10'd1, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[14] = '{3203, 10'd0,   10'd1, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[15] = '{3204, 10'd1,   10'd1, 1'b0, 1'b1, 1'b1, 1'b1};

        repeat (3) @(negedge reloj);
        chk("rst_a_qh",   qh_a,   0);
        chk("rst_a_qv",   qv_a,   0);
        chk("rst_a_tick", tick_a, 0);
        chk("rst_a_hs",   hs_a,   1);
        chk("rst_a_vs",   vs_a,   1);
        chk("rst_a_vo",   vo_a,   0);
        chk("rst_a_fin",  fin_a,  0);
        chk("rst_a_dly",  {hsd_a, vsd_a, vod_a}, 3'b110);
        chk("rst_b_tick", tick_b, 0);
        chk("rst_b_sync", {hs_b, vs_b, vo_b}, 3'b000);

        #1 rst_a = 1'b0;
        k_a = 0;
        #1;
        chk("rel_a_tick", tick_a, 0);
        chk("rel_a_qh",   qh_a,   0);

        for (int i = 0; i < 16; i++) begin
            repeat (tbl[i].k - k_a) @(negedge reloj);
            k_a = tbl[i].k;
            chk($sformatf("tbl%0d_qh", i),   qh_a,   tbl[i].qh);
            chk($sformatf("tbl%0d_qv", i),   qv_a,   tbl[i].qv);
            chk($sformatf("tbl%0d_tick", i), tick_a, tbl[i].tick);
            chk($sformatf("tbl%0d_hs", i),   hs_a,   tbl[i].hs);
            chk($sformatf("tbl%0d_vs", i),   vs_a,   tbl[i].vs);
            chk($sformatf("tbl%0d_vo", i),   vo_a,   tbl[i].vo);
            chk($sformatf("tbl%0d_fin", i),  fin_a,  0);
        end

        // Asynchronous reset mid-line at Qh=300, Qv=1.
        repeat (4401 - k_a) @(negedge reloj);
        chk("pre_rst_qh", qh_a, 300);
        chk("pre_rst_qv", qv_a, 1);
        #2 rst_a = 1'b1;
        #1;
        chk("async_qh",   qh_a, 0);
        chk("async_qv",   qv_a, 0);
        chk("async_vo",   vo_a, 0);
        chk("async_sync", {hs_a, vs_a}, 2'b11);
        chk("async_tick", tick_a, 0);
        chk("async_dly",  {hsd_a, vsd_a, vod_a}, 3'b110);
        repeat (2) @(negedge reloj);
        #1 rst_a = 1'b0;
        repeat (3) @(negedge reloj);
        chk("restart_tick3", tick_a, 1);
        chk("restart_qh3",   qh_a,   0);
        @(negedge reloj);
        chk("restart_qh4",   qh_a,   1);
        chk("restart_tick4", tick_a, 0);
        repeat (4) @(negedge reloj);
        chk("restart_qh8",   qh_a,   2);

        // Whole-frame run on the DIV=1, active-high instance.
        @(negedge reloj);
        #1 rst_b = 1'b0;
        #1;
        chk("b_tick_k0", tick_b, 1);
        fin_seen = 0; hs_cnt = 0; vs_cnt = 0; vo_cnt = 0; tick_cnt = 0;
        bad_vs = 0; run = 0; bad_run = 0; runs = 0;
        prev_fin = 1'b0; prev_hs = 1'b0;
        for (int k = 1; k <= 360; k++) begin
            @(negedge reloj);
            if (prev_fin) begin
                chk("b_after_fin_qh", qh_b, 0);
                chk("b_after_fin_qv", qv_b, 0);
            end
            if (k <= 359 && fin_b) begin
                fin_seen++;
                chk("b_fin_k", k % 180, 179);
                chk("b_fin_qh", qh_b, 14);
                chk("b_fin_qv", qv_b, 11);
            end
            if (k >= 180 && k <= 359) begin
                hs_cnt   += int'(hs_b);
                vs_cnt   += int'(vs_b);
                vo_cnt   += int'(vo_b);
                tick_cnt += int'(tick_b);
                if (vs_b && qv_b != 10'd7 && qv_b != 10'd8) bad_vs++;
                if (hs_b) run++;
                if (!hs_b && prev_hs) begin
                    runs++;
                    if (run != 3) bad_run++;
                    run = 0;
                end
            end
            prev_fin = fin_b;
            prev_hs  = hs_b;
        end
        chk("b_fin_pulses", fin_seen, 2);
        chk("b_hs_clocks",  hs_cnt,   36);
        chk("b_hs_runs",    runs,     12);
        chk("b_hs_badrun",  bad_run,  0);
        chk("b_vs_clocks",  vs_cnt,   30);
        chk("b_vs_rows",    bad_vs,   0);
        chk("b_vo_clocks",  vo_cnt,   48);
        chk("b_ticks",      tick_cnt, 180);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
